alu_rr_arbiter: RTL and testbench
=================================

# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational `alu` core (4-bit operands, 3-bit select, 8-bit result) between two requesters. Each requester presents an operation over a valid/ready handshake. The block grants one requester, registers the operands, and executes through the shared core. It returns the registered result, with source ID and tag, on a single response channel with backpressure. It sits between the pad-level input logic and the core, replacing the fixed input/output register pair when two agents contend for the ALU.

## Interface
- `TAG_W`, default 2: width of the opaque tag carried from request to response.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low. Release is synchronous to `clk`.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b` in 4 each: requester 0 operands.
- `req0_op` in 3: requester 0 ALU select.
- `req0_tag` in `TAG_W`: requester 0 tag.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`, `req1_tag`: same as requester 0, for requester 1.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_result` out 8: ALU result.
- `rsp_src` out 1: index of the requester that issued the operation.
- `rsp_tag` out `TAG_W`: tag of the issuing request.
- `rsp_err` out 1: divide by zero (op 3'b111 with b == 0).
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester indicated by priority pointer `prio`. `prio` resets to 0.
  - `reqN_ready` is combinational: (state == IDLE) && `reqN_valid` && grant == N. At most one ready is high in a cycle.
  - On handshake, capture a, b, op, tag and src into operand registers, then go to EXEC.
- EXEC: drive the core from the operand registers. Register the result, src, tag and err into the response registers. Go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_*` are held stable until `rsp_ready` is high.
  - On handshake, set `prio` to the other requester (not the one just served) and go to IDLE.
- Core op encoding, 8-bit result:
  - 000: a+b.
  - 001: a−b as 8-bit two's complement.
  - 010: and, zero-extended.
  - 011: or, zero-extended.
  - 100: xor, zero-extended.
  - 101: {~b,~a}.
  - 110: a*b.
  - 111: a/b zero-extended. If b == 0, result = 0x00 and `rsp_err` = 1.
- `rsp_err` is 0 for every other case.
- Requesters hold valid and payload stable until ready. The block does not check this; a request whose valid drops before grant is simply not taken.
- Both `reqN_ready` are 0 outside IDLE, so requests arriving during EXEC/RESP wait.

## Timing
- Request accepted at edge T (handshake cycle T). Block is in EXEC in cycle T+1. `rsp_valid` rises in cycle T+2.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP) when `rsp_ready` is held high. Peak throughput is 1 operation per 3 cycles.
- Each cycle `rsp_ready` is low in RESP extends occupancy by one cycle. Outputs do not change during the stall.
- Both valids held high continuously produce strict alternation 0,1,0,1…
- A lone requester is served back-to-back regardless of `prio`.
- Reset values (asynchronous, immediate on `rst_n` low):
  - state = IDLE, `prio` = 0.
  - `req0_ready` = `req1_ready` = 0 while in reset.
  - `rsp_valid` = 0, `rsp_result` = 0x00, `rsp_src` = 0, `rsp_tag` = 0, `rsp_err` = 0, `busy` = 0.
- Reset asserted in EXEC or RESP discards the in-flight operation. No response is produced for it after release.
- First grant is possible in the first cycle after `rst_n` deasserts.

## Test plan
- Single request: req0 a=9, b=8, op=000, tag=2 accepted at T -> `rsp_valid` at T+2 with result 0x11, src 0, tag 2, err 0.
- Contention: both valid every cycle, `rsp_ready`=1, req0 op=110 a=15 b=15, req1 op=001 a=3 b=5 -> responses alternate src 0 (0xE1), src 1 (0xFE), src 0… with one response every 3 cycles.
- Divide: req1 op=111 a=13 b=4 -> 0x03, err 0. Then op=111 a=7 b=0 -> 0x00, err 1.
- Backpressure: `rsp_ready` held low 5 cycles in RESP with req0 op=101 a=0x3 b=0xA -> `rsp_result` 0x5C stable throughout. Both `reqN_ready` stay 0 while req1 is valid. Response completes on the first cycle `rsp_ready`=1, then req1 is granted next in IDLE.
- Reset mid-operation: assert `rst_n`=0 during EXEC -> all outputs go to their reset values immediately. After release, no stale response appears and the first grant goes to requester 0 when both are valid.
- Sweep: all 8 ops × all 256 a/b pairs through requester 0 -> every result matches the encoding above.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two-requester round-robin front end sharing one combinational 4-bit ALU core.

module alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic       err
);
    always_comb begin
        y   = 8'h00;
        err = 1'b0;
        case (op)
            3'b000: y = {4'b0, a} + {4'b0, b};
            3'b001: y = {4'b0, a} - {4'b0, b};
            3'b010: y = {4'b0, a & b};
            3'b011: y = {4'b0, a | b};
            3'b100: y = {4'b0, a ^ b};
            3'b101: y = {~b, ~a};
            3'b110: y = {4'b0, a} * {4'b0, b};
            default: begin
                err = (b == 4'd0);
                y   = err ? 8'h00 : {4'b0, a / b};
            end
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [2:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [2:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             src_q, src_d;
    logic [7:0]       res_q, res_d;
    logic             rsrc_q, rsrc_d;
    logic [TAG_W-1:0] rtag_q, rtag_d;
    logic             err_q, err_d;
    logic [7:0]       alu_y;
    logic             alu_err;
    logic             idle, gnt, take;

    alu u_alu (.a(a_q), .b(b_q), .op(op_q), .y(alu_y), .err(alu_err));

    // Under contention the pointer decides; a lone requester wins regardless of it.
    assign gnt        = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign idle       = rst_n && (state_q == IDLE);
    assign req0_ready = idle && req0_valid && !gnt;
    assign req1_ready = idle && req1_valid && gnt;
    assign take       = req0_ready || req1_ready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tag_d   = tag_q;
        src_d   = src_q;
        res_d   = res_q;
        rsrc_d  = rsrc_q;
        rtag_d  = rtag_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (take) begin
                a_d     = gnt ? req1_a   : req0_a;
                b_d     = gnt ? req1_b   : req0_b;
                op_d    = gnt ? req1_op  : req0_op;
                tag_d   = gnt ? req1_tag : req0_tag;
                src_d   = gnt;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_y;
                err_d   = alu_err;
                rsrc_d  = src_q;
                rtag_d  = tag_q;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                prio_d  = ~rsrc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            src_q   <= 1'b0;
            res_q   <= '0;
            rsrc_q  <= 1'b0;
            rtag_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            src_q   <= src_d;
            res_q   <= res_d;
            rsrc_q  <= rsrc_d;
            rtag_q  <= rtag_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_result = res_q;
    assign rsp_src    = rsrc_q;
    assign rsp_tag    = rtag_q;
    assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: vector table, scoreboard and corner-case sequences for alu_rr_arbiter.

module tb_alu_rr_arbiter;
    localparam int TAG_W = 2;
    localparam int SB_W  = TAG_W + 10;

    typedef logic [SB_W-1:0] sb_t;
    typedef struct {
        logic             s;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic [7:0]       res;
        logic             err;
    } vec_t;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]       req0_op = '0, req1_op = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             rsp_valid, rsp_src, rsp_err, busy;
    logic [7:0]       rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    int  n_tests = 0, n_fail = 0, cyc = 0;
    sb_t sb[$];
    sb_t cur, held;
    logic stall = 1'b0;
    vec_t vecs[11];

    alu_rr_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ia, ib;
        logic [7:0] r;
        logic e;
        ia = int'(a);
        ib = int'(b);
        e  = 1'b0;
        case (op)
            3'd0: r = 8'(ia + ib);
            3'd1: r = 8'(ia - ib);
            3'd2: r = 8'(ia & ib);
            3'd3: r = 8'(ia | ib);
            3'd4: r = 8'(ia ^ ib);
            3'd5: r = 8'(((15 - ib) << 4) | (15 - ia));
            3'd6: r = 8'(ia * ib);
            default: begin
                e = (ib == 0);
                r = e ? 8'h00 : 8'(ia / ib);
            end
        endcase
        return {e, r};
    endfunction

    function automatic sb_t entry(input logic s, input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] op, input logic [TAG_W-1:0] t);
        logic [8:0] m;
        m = model(a, b, op);
        return {m[7:0], s, t, m[8]};
    endfunction

    // Scoreboard: push on request handshake, pop on response handshake, watch stalls for stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stall <= 1'b0;
        end else begin
            if (req0_valid && req0_ready) sb.push_back(entry(1'b0, req0_a, req0_b, req0_op, req0_tag));
            if (req1_valid && req1_ready) sb.push_back(entry(1'b1, req1_a, req1_b, req1_op, req1_tag));
            cur = {rsp_result, rsp_src, rsp_tag, rsp_err};
            if (stall) check("rsp_hold", 32'({rsp_valid, cur}), 32'({1'b1, held}));
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got 0x%0h with empty scoreboard", cur);
                end else begin
                    check("scoreboard", 32'(cur), 32'(sb.pop_front()));
                end
            end
            stall <= rsp_valid && !rsp_ready;
            held  <= cur;
        end
    end

    task automatic drive(input logic s, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [TAG_W-1:0] t);
        if (s) begin
            req1_a = a; req1_b = b; req1_op = op; req1_tag = t; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_tag = t; req0_valid = 1'b1;
        end
    endtask

    task automatic issue(input logic s, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [TAG_W-1:0] t, output bit ok);
        drive(s, a, b, op, t);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (s) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rsp_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        issue(v.s, v.a, v.b, v.op, v.tag, ok);
        @(negedge clk);
        check("exec_busy_novalid", 32'({busy, rsp_valid}), 32'b10);
        @(negedge clk);
        check("rsp_valid_t2", 32'(rsp_valid), 32'd1);
        check("vec_result", 32'(rsp_result), 32'(v.res));
        check("vec_src", 32'(rsp_src), 32'(v.s));
        check("vec_tag", 32'(rsp_tag), 32'(v.tag));
        check("vec_err", 32'(rsp_err), 32'(v.err));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_rsp_src_tag_err"}, 32'({rsp_src, rsp_tag, rsp_err}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_readies"}, 32'({req0_ready, req1_ready}), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        int last;
        vecs[0]  = '{1'b0, 4'd9,  4'd8,  3'd0, 2'd2, 8'h11, 1'b0};
        vecs[1]  = '{1'b1, 4'd3,  4'd5,  3'd1, 2'd1, 8'hFE, 1'b0};
        vecs[2]  = '{1'b0, 4'd15, 4'd15, 3'd6, 2'd3, 8'hE1, 1'b0};
        vecs[3]  = '{1'b1, 4'd13, 4'd4,  3'd7, 2'd0, 8'h03, 1'b0};
        vecs[4]  = '{1'b1, 4'd7,  4'd0,  3'd7, 2'd2, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 4'h3,  4'hA,  3'd5, 2'd1, 8'h5C, 1'b0};
        vecs[6]  = '{1'b1, 4'hC,  4'hA,  3'd2, 2'd3, 8'h08, 1'b0};
        vecs[7]  = '{1'b0, 4'h5,  4'hA,  3'd3, 2'd0, 8'h0F, 1'b0};
        vecs[8]  = '{1'b1, 4'hF,  4'h3,  3'd4, 2'd2, 8'h0C, 1'b0};
        vecs[9]  = '{1'b0, 4'h0,  4'h1,  3'd1, 2'd1, 8'hFF, 1'b0};
        vecs[10] = '{1'b1, 4'hF,  4'hF,  3'd0, 2'd0, 8'h1E, 1'b0};

        // Reset state, with both requesters asserting valid.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Contention: pointer restarts at 0, responses alternate every 3 cycles.
        rst_n = 1'b0;
        drive(1'b0, 4'd15, 4'd15, 3'd6, 2'd1);
        drive(1'b1, 4'd3, 4'd5, 3'd1, 2'd2);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(ok);
            check("rr_src", 32'(rsp_src), 32'(k % 2));
            check("rr_result", 32'(rsp_result), (k % 2) ? 32'hFE : 32'hE1);
            if (k > 0) check("rr_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: 5 stalled RESP cycles, req1 waits, then wins the next IDLE.
        rsp_ready = 1'b0;
        issue(1'b0, 4'h3, 4'hA, 3'd5, 2'd1, ok);
        drive(1'b1, 4'd1, 4'd1, 3'd0, 2'd2);
        @(negedge clk);
        check("bp_exec_ready1", 32'(req1_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", 32'(rsp_result), 32'h5C);
            check("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_complete", 32'({rsp_valid, rsp_src}), 32'b10);
        @(negedge clk);
        check("bp_req1_granted", 32'({busy, req1_ready}), 32'b01);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_rsp(ok);
        check("bp_req1_rsp", 32'({rsp_src, rsp_result}), 32'h102);
        @(posedge clk);
        #1;

        // Reset during EXEC after req0 was served (pointer at 1): pointer must return to 0.
        run_vec(vecs[0]);
        issue(1'b0, 4'd1, 4'd2, 3'd0, 2'd3, ok);
        #1 rst_n = 1'b0;
        drive(1'b0, 4'd4, 4'd6, 3'd6, 2'd1);
        drive(1'b1, 4'd2, 4'd2, 3'd0, 2'd2);
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_grant", 32'({req0_ready, req1_ready, rsp_valid}), 32'b100);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(ok);
        check("post_reset_rsp", 32'({rsp_src, rsp_result, rsp_tag}), 32'({1'b0, 8'h18, 2'd1}));
        @(posedge clk);
        #1;

        // Exhaustive sweep through requester 0, checked by the scoreboard.
        for (int op = 0; op < 8; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    issue(1'b0, 4'(a), 4'(b), 3'(op), 2'(b), ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("sb_drain", 32'(ok), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
